// File: rtl/flit_req_port_if.sv
// Signal bundle for flit_req_port: upstream flit input, arbiter req/grant/update
// handshake and downstream flit output. The design uses the slave modport.
interface flit_req_port_if #(parameter int FLIT_W = 32);
  logic              in_valid_i, in_ready_o, in_head_i, in_tail_i;
  logic [FLIT_W-1:0] in_data_i;
  logic              req_o, grant_i, update_o;
  logic              out_valid_o, out_ready_i, out_tail_o;
  logic [FLIT_W-1:0] out_data_o;
  logic              err_o;

  modport slave (
    input  in_valid_i, in_data_i, in_head_i, in_tail_i, grant_i, out_ready_i,
    output in_ready_o, req_o, update_o, out_valid_o, out_data_o, out_tail_o, err_o
  );
  modport master (
    output in_valid_i, in_data_i, in_head_i, in_tail_i, grant_i, out_ready_i,
    input  in_ready_o, req_o, update_o, out_valid_o, out_data_o, out_tail_o, err_o
  );
endinterface

// File: rtl/flit_req_port.sv
// Requester port in front of one round-robin arbiter input: queues flits, requests on a
// queued head, streams a whole packet per grant. Optional grant timeout: FLIT_REQ_TIMEOUT_EN.
module flit_req_port #(
  parameter int         FLIT_W      = 32,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input logic            clk,
  input logic            arst,
  flit_req_port_if.slave p
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic              head;
    logic              tail;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]        count_q, count_d;
  state_e             state_q, state_d;
  logic               err_q, err_d;
  entry_t             front;
  logic               nonempty, in_ready, push, out_valid, accept, drop, pop;

`ifdef FLIT_REQ_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_comb begin
    front     = mem_q[rd_ptr_q];
    nonempty  = (count_q != '0);
    in_ready  = (count_q != (PW+1)'(DEPTH));
    push      = p.in_valid_i & in_ready;
    out_valid = (state_q == XFER) & nonempty & p.grant_i;
    accept    = out_valid & p.out_ready_i;
    // A non-head flit at the front while idle cannot start a packet: discard it.
    drop      = (state_q == IDLE) & nonempty & ~front.head;
    pop       = accept | drop;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: p.in_data_i, head: p.in_head_i, tail: p.in_tail_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q | drop;
`ifdef FLIT_REQ_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      IDLE: if (nonempty & front.head) begin
        state_d = REQ;
`ifdef FLIT_REQ_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      REQ: if (p.grant_i) begin
        state_d = XFER;
`ifdef FLIT_REQ_TIMEOUT_EN
      end else begin
        // Give up for one cycle; the packet stays queued and is re-requested.
        wait_d = wait_q + 8'd1;
        if (wait_d == TIMEOUT_CYC) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      XFER: if (accept & front.tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      err_q    <= 1'b0;
`ifdef FLIT_REQ_TIMEOUT_EN
      wait_q   <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      err_q    <= err_d;
`ifdef FLIT_REQ_TIMEOUT_EN
      wait_q   <= wait_d;
`endif
    end
  end

  // update rides the tail beat combinationally so the arbiter rotates while req/grant are high
  assign p.in_ready_o  = in_ready;
  assign p.req_o       = (state_q != IDLE);
  assign p.out_valid_o = out_valid;
  assign p.out_data_o  = front.data;
  assign p.out_tail_o  = front.tail;
  assign p.update_o    = accept & front.tail;
  assign p.err_o       = err_q;
endmodule

// File: tb/tb_flit_req_port.sv
// Bench for flit_req_port: cycle table, directed corner sequences, then random traffic
// compared against a queue-based reference model.
module tb_flit_req_port;
  logic clk = 1'b0;
  logic arst = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  flit_req_port_if #(.FLIT_W(32)) bus ();
  flit_req_port #(.FLIT_W(32), .DEPTH(4), .TIMEOUT_CYC(8'd255)) dut (
    .clk(clk), .arst(arst), .p(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout expected $finish");
    $fatal(1);
  end

  typedef struct {
    bit v, h, t; logic [31:0] d; bit g, r;
    bit req, rdy, vld, upd, err; logic [31:0] od;
  } vec_t;
  typedef struct { logic [31:0] d; bit h; bit t; } flit_t;

  vec_t  tv[21];
  flit_t mq[$];
  flit_t pend[$];
  int    mmode, mwait, n;
  bit    merr, rv, rg, rr, e_rdy, e_vld, e_upd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle's inputs just after the falling edge; outputs settle #1 later
  task automatic cyc(input bit v, h, t, input logic [31:0] d, input bit g, r);
    @(negedge clk);
    bus.in_valid_i = v; bus.in_head_i = h; bus.in_tail_i = t; bus.in_data_i = d;
    bus.grant_i = g; bus.out_ready_i = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b0;
    bus.in_valid_i = 0; bus.in_head_i = 0; bus.in_tail_i = 0; bus.in_data_i = '0;
    bus.grant_i = 0; bus.out_ready_i = 0;
    @(negedge clk);
    arst = 1'b1;
  endtask

  task automatic gen_packet();
    int len;
    if ($urandom_range(19) == 0) begin
      pend.push_back('{d: $urandom, h: 1'b0, t: 1'($urandom_range(1))});
    end else begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        pend.push_back('{d: $urandom, h: (i == 0), t: (i == len - 1)});
    end
  endtask

  initial begin
    bus.in_valid_i = 0; bus.in_head_i = 0; bus.in_tail_i = 0; bus.in_data_i = '0;
    bus.grant_i = 0; bus.out_ready_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.req_o, 0);
    chk("rst_rdy", bus.in_ready_o, 1);
    chk("rst_vld", bus.out_valid_o, 0);
    chk("rst_upd", bus.update_o, 0);
    chk("rst_err", bus.err_o, 0);
    arst = 1'b1;

    // single flit, 3-flit with out_ready toggling, stray non-head then normal packet
    tv[0]  = '{1,1,1,32'hA5A5A5A5,0,1, 0,1,0,0,0, 0};
    tv[1]  = '{0,0,0,0,0,1, 0,1,0,0,0, 0};
    tv[2]  = '{0,0,0,0,1,1, 1,1,0,0,0, 0};
    tv[3]  = '{0,0,0,0,1,1, 1,1,1,1,0, 32'hA5A5A5A5};
    tv[4]  = '{0,0,0,0,0,1, 0,1,0,0,0, 0};
    tv[5]  = '{1,1,0,1,0,1, 0,1,0,0,0, 0};
    tv[6]  = '{1,0,0,2,0,1, 0,1,0,0,0, 0};
    tv[7]  = '{1,0,1,3,1,1, 1,1,0,0,0, 0};
    tv[8]  = '{0,0,0,0,1,1, 1,1,1,0,0, 1};
    tv[9]  = '{0,0,0,0,1,0, 1,1,1,0,0, 2};
    tv[10] = '{0,0,0,0,1,1, 1,1,1,0,0, 2};
    tv[11] = '{0,0,0,0,1,0, 1,1,1,0,0, 3};
    tv[12] = '{0,0,0,0,1,1, 1,1,1,1,0, 3};
    tv[13] = '{0,0,0,0,0,1, 0,1,0,0,0, 0};
    tv[14] = '{1,0,1,32'h55,0,1, 0,1,0,0,0, 0};
    tv[15] = '{0,0,0,0,0,1, 0,1,0,0,0, 0};
    tv[16] = '{1,1,1,32'h66,0,1, 0,1,0,0,1, 0};
    tv[17] = '{0,0,0,0,0,1, 0,1,0,0,1, 0};
    tv[18] = '{0,0,0,0,1,1, 1,1,0,0,1, 0};
    tv[19] = '{0,0,0,0,1,1, 1,1,1,1,1, 32'h66};
    tv[20] = '{0,0,0,0,0,1, 0,1,0,0,1, 0};
    for (int i = 0; i < 21; i++) begin
      cyc(tv[i].v, tv[i].h, tv[i].t, tv[i].d, tv[i].g, tv[i].r);
      chk($sformatf("v%0d_req", i), bus.req_o, tv[i].req);
      chk($sformatf("v%0d_rdy", i), bus.in_ready_o, tv[i].rdy);
      chk($sformatf("v%0d_vld", i), bus.out_valid_o, tv[i].vld);
      chk($sformatf("v%0d_upd", i), bus.update_o, tv[i].upd);
      chk($sformatf("v%0d_err", i), bus.err_o, tv[i].err);
      if (tv[i].vld) chk($sformatf("v%0d_data", i), bus.out_data_o, tv[i].od);
    end

    // fill to DEPTH, rejected 5th push, no-bypass ready, grant dropped mid-packet
    do_reset();
    cyc(1,1,0,32'h10,0,0); chk("fill_rdy0", bus.in_ready_o, 1);
    cyc(1,0,0,32'h11,0,0);
    cyc(1,0,0,32'h12,0,0); chk("fill_req", bus.req_o, 1);
    cyc(1,0,1,32'h13,0,0);
    cyc(1,1,1,32'h99,0,0); chk("full_rdy", bus.in_ready_o, 0);
    cyc(0,0,0,0,1,0);      chk("full_rdy2", bus.in_ready_o, 0); chk("full_vld", bus.out_valid_o, 0);
    cyc(0,0,0,0,1,1);      chk("pop_vld", bus.out_valid_o, 1); chk("pop_data", bus.out_data_o, 32'h10);
    chk("nobypass_rdy", bus.in_ready_o, 0);
    cyc(0,0,0,0,1,1);      chk("after_pop_rdy", bus.in_ready_o, 1); chk("beat2", bus.out_data_o, 32'h11);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,0,1);
      chk($sformatf("gdrop%0d_vld", i), bus.out_valid_o, 0);
      chk($sformatf("gdrop%0d_req", i), bus.req_o, 1);
      chk($sformatf("gdrop%0d_upd", i), bus.update_o, 0);
    end
    cyc(0,0,0,0,1,1); chk("resume_data", bus.out_data_o, 32'h12); chk("resume_upd", bus.update_o, 0);
    cyc(0,0,0,0,1,1); chk("tail_data", bus.out_data_o, 32'h13); chk("tail_upd", bus.update_o, 1);
    chk("tail_vld", bus.out_valid_o, 1);
    cyc(0,0,0,0,0,1); chk("post_req", bus.req_o, 0);
    cyc(0,0,0,0,0,1); chk("post_req2", bus.req_o, 0);
    cyc(0,0,0,0,0,1); chk("no5th_err", bus.err_o, 0); chk("no5th_req", bus.req_o, 0);

    // async reset mid-transfer with 2 flits queued
    cyc(1,1,0,32'h20,0,0);
    cyc(1,0,0,32'h21,0,0);
    cyc(0,0,0,0,1,0); chk("ar_req", bus.req_o, 1);
    cyc(0,0,0,0,1,0); chk("ar_vld", bus.out_valid_o, 1); chk("ar_data", bus.out_data_o, 32'h20);
    bus.out_ready_i = 1; arst = 1'b0;
    #1;
    chk("ar_async_req", bus.req_o, 0);
    chk("ar_async_vld", bus.out_valid_o, 0);
    chk("ar_async_upd", bus.update_o, 0);
    chk("ar_async_rdy", bus.in_ready_o, 1);
    @(negedge clk); arst = 1'b1;
    cyc(0,0,0,0,1,1); chk("ar_after_req", bus.req_o, 0); chk("ar_after_vld", bus.out_valid_o, 0);
    cyc(0,0,0,0,1,1); chk("ar_after_req2", bus.req_o, 0); chk("ar_after_err", bus.err_o, 0);

`ifdef FLIT_REQ_TIMEOUT_EN
    do_reset();
    cyc(1,1,1,32'h77,0,0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(0,0,0,0,0,0);
      if (bus.req_o) n++;
      else if (n > 0) break;
    end
    chk("to_len", n, 255);
    chk("to_err", bus.err_o, 1);
    cyc(0,0,0,0,0,0); chk("to_rereq", bus.req_o, 1);
`endif

    // random traffic against the reference model
    do_reset();
    mq.delete(); pend.delete(); mmode = 0; mwait = 0; merr = 0;
    for (int c = 0; c < 800; c++) begin
      if (pend.size() == 0) gen_packet();
      rv = ($urandom_range(3) != 0);
      rg = (mmode != 0) && ($urandom_range(4) != 0);
      rr = ($urandom_range(3) != 0);
      cyc(rv, pend[0].h, pend[0].t, pend[0].d, rg, rr);
      e_rdy = (mq.size() != 4);
      e_vld = (mmode == 2) && (mq.size() > 0) && rg;
      e_upd = e_vld && rr && mq[0].t;
      chk("rnd_req", bus.req_o, (mmode != 0));
      chk("rnd_rdy", bus.in_ready_o, e_rdy);
      chk("rnd_vld", bus.out_valid_o, e_vld);
      chk("rnd_upd", bus.update_o, e_upd);
      chk("rnd_err", bus.err_o, merr);
      if (e_vld) begin
        chk("rnd_data", bus.out_data_o, mq[0].d);
        chk("rnd_tail", bus.out_tail_o, mq[0].t);
      end
      // advance the model across the coming rising edge
      case (mmode)
        0: if (mq.size() > 0) begin
          if (!mq[0].h) begin void'(mq.pop_front()); merr = 1; end
          else begin mmode = 1; mwait = 0; end
        end
        1: if (rg) mmode = 2;
`ifdef FLIT_REQ_TIMEOUT_EN
        else begin
          mwait++;
          if (mwait == 255) begin mmode = 0; merr = 1; end
        end
`endif
        default: if (e_vld && rr) begin
          if (mq[0].t) mmode = 0;
          void'(mq.pop_front());
        end
      endcase
      if (rv && e_rdy) mq.push_back(pend.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
